// File: rtl/avalon_pkg.sv
// Shared types and constants for the two-master Avalon arbiter.
//   arb_state_t : arbiter FSM states
//   mreq_t      : one master's request bundle (read, write, addr, wdata)
//   DW, AW      : default data/address widths; ABORT_DATA is the read data
//                 returned to a master whose transfer is aborted by the timeout.
package avalon_pkg;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam logic [15:0] ABORT_DATA = 16'hDEAD;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;
endpackage

// File: rtl/avalon_arbiter_rr_pick.sv
// rr_pick: two-input round-robin picker, purely combinational.
//   req[1:0] : request per master
//   last     : master granted most recently
//   valid    : at least one request present
//   sel      : chosen master; on a tie the one that was not granted last
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);
  assign valid = |req;
  assign sel   = (&req) ? ~last : req[1];
endmodule

// File: rtl/avalon_arbiter.sv
// avalon_arbiter: two-master round-robin arbiter in front of one Avalon slave.
// The grant is held from arbitration until the slave completes the transfer;
// every transfer returns through IDLE, so back-to-back requests see one bubble.
//   Clock, Resetn           : clock, synchronous active-low reset
//   Mx_Read/Write/Addr/WData: master x request, Mx_Waitreq: stall to master x
//   M_RData                 : shared read data, valid for the owner when its
//                             Waitreq is 0
//   S_*                     : slave side; S_Waitreq stalls the owner
//   Error                   : one-cycle pulse when a transfer is aborted
// Build option: define ARB_TIMEOUT_EN to abort a transfer after TIMEOUT stalled
// BUSY cycles; otherwise BUSY waits forever and Error is tied low.
// DW/AW must equal the package widths because the request bundle uses them.
module avalon_arbiter #(
  parameter int DW      = avalon_pkg::DW,
  parameter int AW      = avalon_pkg::AW,
  parameter int TIMEOUT = 255
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          M0_Read,
  input  logic          M0_Write,
  input  logic [AW-1:0] M0_Addr,
  input  logic [DW-1:0] M0_WData,
  output logic          M0_Waitreq,
  input  logic          M1_Read,
  input  logic          M1_Write,
  input  logic [AW-1:0] M1_Addr,
  input  logic [DW-1:0] M1_WData,
  output logic          M1_Waitreq,
  output logic [DW-1:0] M_RData,
  output logic          S_Read,
  output logic          S_Write,
  output logic [AW-1:0] S_Addr,
  output logic [DW-1:0] S_WData,
  input  logic [DW-1:0] S_RData,
  input  logic          S_Waitreq,
  output logic          Error
);
  import avalon_pkg::*;

  arb_state_t state;
  logic       owner, lastGrant;
  mreq_t      req0, req1, own;
  logic       ownReq, busy, abort, pickValid, pickSel;

  assign req0   = '{read: M0_Read, write: M0_Write, addr: M0_Addr, wdata: M0_WData};
  assign req1   = '{read: M1_Read, write: M1_Write, addr: M1_Addr, wdata: M1_WData};
  assign own    = owner ? req1 : req0;
  assign ownReq = own.read | own.write;
  assign busy   = (state == BUSY);

  rr_pick uPick (
    .req   ({req1.read | req1.write, req0.read | req0.write}),
    .last  (lastGrant),
    .valid (pickValid),
    .sel   (pickSel)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  logic [CW-1:0] stallCnt;

  // Held at zero outside BUSY, so every BUSY entry starts counting from 0.
  always_ff @(posedge Clock) begin
    if (!Resetn)        stallCnt <= '0;
    else if (!busy)     stallCnt <= '0;
    else if (S_Waitreq) stallCnt <= stallCnt + 1'b1;
  end

  assign abort = busy && (stallCnt == TO_CNT);
`else
  assign abort = 1'b0;
`endif

  assign Error = abort;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (pickValid) begin
          owner <= pickSel;
          state <= BUSY;
        end
        BUSY: begin
          if (abort || (ownReq && !S_Waitreq)) begin
            lastGrant <= owner;
            state     <= IDLE;
          end else if (!ownReq) begin
            // owner withdrew mid-transfer: no completion, round-robin untouched
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    S_Read     = 1'b0;
    S_Write    = 1'b0;
    S_Addr     = '0;
    S_WData    = '0;
    M_RData    = '0;
    M0_Waitreq = 1'b1;
    M1_Waitreq = 1'b1;
    if (busy) begin
      // read+write together is treated as a write
      S_Write = own.write & ~abort;
      S_Read  = own.read & ~own.write & ~abort;
      S_Addr  = own.addr;
      S_WData = own.wdata;
      M_RData = abort ? DW'(ABORT_DATA) : S_RData;
      if (owner) M1_Waitreq = S_Waitreq & ~abort;
      else       M0_Waitreq = S_Waitreq & ~abort;
    end
  end
endmodule

// File: tb/tb_avalon_arbiter.sv
// Table-driven bench for avalon_arbiter: each row gives one cycle of inputs and
// the outputs expected in that same cycle; expectations go through a queue
// and are popped and compared on the falling edge.
module tb_avalon_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          M0_Read, M0_Write, M1_Read, M1_Write;
  logic [AW-1:0] M0_Addr, M1_Addr, S_Addr;
  logic [DW-1:0] M0_WData, M1_WData, S_WData, S_RData, M_RData;
  logic          M0_Waitreq, M1_Waitreq, S_Read, S_Write, S_Waitreq, Error;

  always #5 Clock = ~Clock;

  avalon_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .M0_Read(M0_Read), .M0_Write(M0_Write), .M0_Addr(M0_Addr), .M0_WData(M0_WData),
    .M0_Waitreq(M0_Waitreq),
    .M1_Read(M1_Read), .M1_Write(M1_Write), .M1_Addr(M1_Addr), .M1_WData(M1_WData),
    .M1_Waitreq(M1_Waitreq),
    .M_RData(M_RData), .S_Read(S_Read), .S_Write(S_Write), .S_Addr(S_Addr),
    .S_WData(S_WData), .S_RData(S_RData), .S_Waitreq(S_Waitreq), .Error(Error)
  );

  typedef struct packed {
    logic rstn; logic [1:0] m0; logic [15:0] m0a, m0d;
    logic [1:0] m1; logic [15:0] m1a, m1d; logic sw; logic [15:0] srd;
  } stim_t;
  typedef struct packed {
    logic sr, sw; logic [15:0] sa, sd; logic w0, w1; logic [15:0] rd; logic err;
  } exp_t;
  typedef struct packed { stim_t s; exp_t e; } vec_t;

  localparam logic [1:0] N = 2'b00, R = 2'b10, W = 2'b01, RW = 2'b11;

  vec_t  tbl[$];
  exp_t  sb[$];
  int    nCmp = 0, nBad = 0;
  string phase;
  exp_t  eI;

  function automatic stim_t st(input logic rstn, input logic [1:0] m0,
      input logic [15:0] m0a, m0d, input logic [1:0] m1,
      input logic [15:0] m1a, m1d, input logic sw, input logic [15:0] srd);
    return '{rstn: rstn, m0: m0, m0a: m0a, m0d: m0d, m1: m1, m1a: m1a,
             m1d: m1d, sw: sw, srd: srd};
  endfunction

  function automatic exp_t ex(input logic sr, sw, input logic [15:0] sa, sd,
      input logic w0, w1, input logic [15:0] rd, input logic err);
    return '{sr: sr, sw: sw, sa: sa, sd: sd, w0: w0, w1: w1, rd: rd, err: err};
  endfunction

  task automatic step(input stim_t s, input exp_t e, input int idx);
    exp_t got, want;
    Resetn   = s.rstn;
    M0_Read  = s.m0[1]; M0_Write = s.m0[0]; M0_Addr = s.m0a; M0_WData = s.m0d;
    M1_Read  = s.m1[1]; M1_Write = s.m1[0]; M1_Addr = s.m1a; M1_WData = s.m1d;
    S_Waitreq = s.sw;   S_RData  = s.srd;
    sb.push_back(e);
    @(negedge Clock);
    got  = '{sr: S_Read, sw: S_Write, sa: S_Addr, sd: S_WData, w0: M0_Waitreq,
             w1: M1_Waitreq, rd: M_RData, err: Error};
    want = sb.pop_front();
    nCmp++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s[%0d]: got {sr,sw,sa,sd,w0,w1,rd,err}=%h want %h",
               phase, idx, got, want);
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    eI = ex(0, 0, 16'h0, 16'h0, 1, 1, 16'h0, 0);
    Resetn = 1'b0; M0_Read = 0; M0_Write = 0; M1_Read = 0; M1_Write = 0;
    M0_Addr = '0; M0_WData = '0; M1_Addr = '0; M1_WData = '0;
    S_Waitreq = 0; S_RData = '0;
    repeat (2) @(posedge Clock);
    #1;

    // single M0 read, zero-wait slave
    tbl.push_back({st(0, R, 16'h0040, 16'h1111, N, 16'h0, 16'h0, 0, 16'h1234), eI});
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, N, 16'h0, 16'h0, 0, 16'h1234), eI});
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, N, 16'h0, 16'h0, 0, 16'h1234),
                   ex(1, 0, 16'h0040, 16'h1111, 0, 1, 16'h1234, 0)});
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, N, 16'h0, 16'h0, 0, 16'h1234), eI});
    // reset, then continuous contention: M0, M1, M0, M1
    tbl.push_back({st(0, R, 16'h0010, 16'h1111, W, 16'h0020, 16'h5555, 0, 16'hAAAA), eI});
    tbl.push_back({st(1, R, 16'h0010, 16'h1111, W, 16'h0020, 16'h5555, 0, 16'hAAAA), eI});
    for (int k = 0; k < 2; k++) begin
      tbl.push_back({st(1, R, 16'h0010, 16'h1111, W, 16'h0020, 16'h5555, 0, 16'hAAAA),
                     ex(1, 0, 16'h0010, 16'h1111, 0, 1, 16'hAAAA, 0)});
      tbl.push_back({st(1, R, 16'h0010, 16'h1111, W, 16'h0020, 16'h5555, 0, 16'hAAAA), eI});
      tbl.push_back({st(1, R, 16'h0010, 16'h1111, W, 16'h0020, 16'h5555, 0, 16'hAAAA),
                     ex(0, 1, 16'h0020, 16'h5555, 1, 0, 16'hAAAA, 0)});
      if (k == 0)
        tbl.push_back({st(1, R, 16'h0010, 16'h1111, W, 16'h0020, 16'h5555, 0, 16'hAAAA), eI});
    end
    tbl.push_back({st(1, N, 16'h0010, 16'h1111, N, 16'h0020, 16'h5555, 0, 16'hAAAA), eI});
    // M1 write with 5 wait states while M0 waits
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F), eI});
    for (int k = 0; k < 5; k++)
      tbl.push_back({st(1, R, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F),
                     ex(0, 1, 16'h0100, 16'hBEEF, 1, 1, 16'h0F0F, 0)});
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 0, 16'h0F0F),
                   ex(0, 1, 16'h0100, 16'hBEEF, 1, 0, 16'h0F0F, 0)});
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, N, 16'h0100, 16'hBEEF, 0, 16'h0F0F), eI});
    // M0 completes (last grant = M0), M1 granted, reset mid-BUSY, tie goes to M0
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, N, 16'h0100, 16'hBEEF, 0, 16'h0F0F),
                   ex(1, 0, 16'h0040, 16'h1111, 0, 1, 16'h0F0F, 0)});
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F), eI});
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F),
                   ex(0, 1, 16'h0100, 16'hBEEF, 1, 1, 16'h0F0F, 0)});
    tbl.push_back({st(0, R, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F),
                   ex(0, 1, 16'h0100, 16'hBEEF, 1, 1, 16'h0F0F, 0)});
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F), eI});
    tbl.push_back({st(1, R, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F),
                   ex(1, 0, 16'h0040, 16'h1111, 1, 1, 16'h0F0F, 0)});
    // M0 withdraws mid-BUSY: back to IDLE, then pending M1 is granted
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 1, 16'h0F0F),
                   ex(0, 0, 16'h0040, 16'h1111, 1, 1, 16'h0F0F, 0)});
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 0, 16'h0F0F), eI});
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, W, 16'h0100, 16'hBEEF, 0, 16'h0F0F),
                   ex(0, 1, 16'h0100, 16'hBEEF, 1, 0, 16'h0F0F, 0)});
    tbl.push_back({st(1, N, 16'h0040, 16'h1111, N, 16'h0100, 16'hBEEF, 0, 16'h0F0F), eI});
    // read and write together behaves as a write
    tbl.push_back({st(1, RW, 16'h0002, 16'h0303, N, 16'h0, 16'h0, 0, 16'h0F0F), eI});
    tbl.push_back({st(1, RW, 16'h0002, 16'h0303, N, 16'h0, 16'h0, 0, 16'h0F0F),
                   ex(0, 1, 16'h0002, 16'h0303, 0, 1, 16'h0F0F, 0)});
    tbl.push_back({st(1, N, 16'h0002, 16'h0303, N, 16'h0, 16'h0, 0, 16'h0F0F), eI});

    phase = "table";
    foreach (tbl[i]) step(tbl[i].s, tbl[i].e, i);

    // long stall on an M0 write
    phase = "stall";
    step(st(1, W, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 1, 16'h2222), eI, 0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++)
      step(st(1, W, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 1, 16'h2222),
           ex(0, 1, 16'h0008, 16'h7777, 1, 1, 16'h2222, 0), k + 1);
    step(st(1, W, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 1, 16'h2222),
         ex(0, 0, 16'h0008, 16'h7777, 0, 1, 16'hDEAD, 1), TO + 1);
    step(st(1, N, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 1, 16'h2222), eI, TO + 2);
`else
    for (int k = 0; k < 20; k++)
      step(st(1, W, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 1, 16'h2222),
           ex(0, 1, 16'h0008, 16'h7777, 1, 1, 16'h2222, 0), k + 1);
    step(st(1, W, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 0, 16'h2222),
         ex(0, 1, 16'h0008, 16'h7777, 0, 1, 16'h2222, 0), 21);
    step(st(1, N, 16'h0008, 16'h7777, N, 16'h0, 16'h0, 0, 16'h2222), eI, 22);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
